// File: rtl/prbs_job_scheduler.sv
// Job scheduler for one PRBS_15 byte core: queues pattern jobs,
// loads/resets/enables the core per job and tags the returned bytes.
// Ports:
//   i_clk, i_rst (async, active-low)
//   job in  : i_job_valid/o_job_ready, i_job_pattern, i_job_reps, i_job_rnd
//   control : i_abort, o_busy, o_job_done
//   core    : o_prbs_rst, o_prbs_en, o_prbs_bytes, o_prbs_n, i_prbs_byte
//   stream  : o_byte_out, o_byte_valid, o_byte_is_pat
`timescale 1ns/1ps
module prbs_job_scheduler #(
  parameter int RND_W   = 8,
  parameter int Q_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_job_valid,
  output logic             o_job_ready,
  input  logic [31:0]      i_job_pattern,
  input  logic [7:0]       i_job_reps,
  input  logic [RND_W-1:0] i_job_rnd,
  input  logic             i_abort,
  output logic             o_prbs_rst,
  output logic             o_prbs_en,
  output logic [31:0]      o_prbs_bytes,
  output logic [7:0]       o_prbs_n,
  input  logic [7:0]       i_prbs_byte,
  output logic [7:0]       o_byte_out,
  output logic             o_byte_valid,
  output logic             o_byte_is_pat,
  output logic             o_job_done,
  output logic             o_busy
);

  localparam int AW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CW = (RND_W > 10) ? RND_W : 10;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PAT, S_RND, S_FIN
  } state_t;

  state_t r_state, w_next;

  logic [31:0]      r_q_pat  [Q_DEPTH];
  logic [7:0]       r_q_reps [Q_DEPTH];
  logic [RND_W-1:0] r_q_rnd  [Q_DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_cnt;
  logic             r_up;

  logic [31:0]      r_pat;
  logic [7:0]       r_n;
  logic [RND_W-1:0] r_rnd;
  logic [CW-1:0]    r_left;

  logic r_v1, r_p1, r_v2, r_p2, r_done;
  logic [7:0] r_byte;

  logic w_full, w_empty, w_push, w_pop, w_abort;
  logic w_emit, w_is_pat;
  logic [CW-1:0] w_pat_len, w_rnd_len;

  assign w_full    = (r_cnt == (AW+1)'(Q_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_push    = i_job_valid && o_job_ready;
  // Head leaves the queue on the edge that enters LOAD.
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_abort   = i_abort && (r_state != S_IDLE);
  assign w_pat_len = CW'({r_n, 2'b00});
  assign w_rnd_len = CW'(r_rnd);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_pat[r_wr]  <= i_job_pattern;
      r_q_reps[r_wr] <= i_job_reps;
      r_q_rnd[r_wr]  <= i_job_rnd;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_up  <= 1'b0;
      r_pat <= '0;
      r_n   <= '0;
      r_rnd <= '0;
    end else begin
      r_up  <= 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd  <= r_rd + 1'b1;
        r_pat <= r_q_pat[r_rd];
        r_n   <= r_q_reps[r_rd];
        r_rnd <= r_q_rnd[r_rd];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (!w_empty) w_next = S_LOAD;
      S_LOAD: begin
        if (r_n != 8'd0)       w_next = S_PAT;
        else if (r_rnd != '0)  w_next = S_RND;
        else                   w_next = S_FIN;
      end
      S_PAT: if (r_left == '0)
               w_next = (r_rnd != '0) ? S_RND : S_FIN;
      S_RND: if (r_left == '0) w_next = S_FIN;
      S_FIN: if (r_left == '0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_comb begin
    w_emit     = (r_state == S_PAT) || (r_state == S_RND);
    w_is_pat   = (r_state == S_PAT);
    o_prbs_en  = w_emit;
    o_prbs_rst = w_emit || (r_state == S_FIN);
    o_busy     = (r_state != S_IDLE);
  end

  // r_left holds remaining cycles minus one in the current phase;
  // FIN always lasts two cycles.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_left <= '0;
    end else if (r_state == S_LOAD) begin
      if (r_n != 8'd0)      r_left <= w_pat_len - ONE;
      else if (r_rnd != '0) r_left <= w_rnd_len - ONE;
      else                  r_left <= ONE;
    end else if (r_left != '0) begin
      r_left <= r_left - ONE;
    end else if (r_state == S_PAT) begin
      r_left <= (r_rnd != '0) ? w_rnd_len - ONE : ONE;
    end else if (r_state == S_RND) begin
      r_left <= ONE;
    end
  end

  // Two stages: one for the core register, one for r_byte.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_v1   <= 1'b0;
      r_p1   <= 1'b0;
      r_v2   <= 1'b0;
      r_p2   <= 1'b0;
      r_byte <= '0;
      r_done <= 1'b0;
    end else begin
      r_byte <= i_prbs_byte;
      r_done <= (r_state == S_FIN) && (r_left == '0)
                && !w_abort;
      if (w_abort) begin
        r_v1 <= 1'b0;
        r_p1 <= 1'b0;
        r_v2 <= 1'b0;
        r_p2 <= 1'b0;
      end else begin
        r_v1 <= w_emit;
        r_p1 <= w_is_pat;
        r_v2 <= r_v1;
        r_p2 <= r_p1;
      end
    end
  end

  assign o_job_ready   = r_up && !w_full;
  assign o_prbs_bytes  = r_pat;
  assign o_prbs_n      = r_n;
  assign o_byte_out    = r_byte;
  assign o_byte_valid  = r_v2;
  assign o_byte_is_pat = r_p2;
  assign o_job_done    = r_done;

endmodule
